rc4_key_search_ctrl: RTL
========================

# rc4_key_search_ctrl

Brute-force key-search scheduler for the RC4 decrypt core. It walks a key range and, for each candidate key, resets and launches the decrypt core. It then scans the decrypted-message RAM for printable text (lowercase a–z or space) and either stops on the first key whose whole message passes, or reports the range exhausted. It sits above the decrypt core and owns its reset, start and key inputs, plus the read port of the decrypted-message RAM.

## Interface
Parameters:
- KEY_W, 24, candidate key width
- KEY_START, 0, first key tried
- KEY_END, 24'h3FFFFF, last key tried (inclusive); requires KEY_END ≥ KEY_START
- MSG_LEN, 32, bytes checked per key; power of two
- ADDR_W, 5, log2(MSG_LEN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin search; sampled in IDLE, FOUND, FAIL only
- key  out  KEY_W  current candidate key to decrypt core
- core_reset  out  1  reset to decrypt core
- core_start  out  1  decrypt_start to decrypt core (level)
- core_complete  in  1  decrypt_complete from core; held high until core reset
- msg_addr  out  ADDR_W  decrypted-message RAM read address
- msg_q  in  8  RAM read data; valid the cycle after msg_addr is presented
- busy  out  1  search in progress
- found  out  1  key holds a passing key
- exhausted  out  1  KEY_END tried and failed

## Operation
- States: IDLE, LOAD, RUN, RD_ADDR, RD_WAIT, TEST, NEXT, FOUND, FAIL.
- IDLE: start=1 → key←KEY_START, go LOAD.
- LOAD: one cycle. core_reset=1. → RUN.
- RUN: core_start=1 held. When core_complete=1: byte index←0, go RD_ADDR.
- RD_ADDR: msg_addr=index. → RD_WAIT.
- RD_WAIT: msg_addr held. → TEST.
- TEST: msg_q is valid if it is in 8'h61–8'h7A or equals 8'h20.
  - Invalid → NEXT.
  - Valid and index=MSG_LEN-1 → FOUND.
  - Otherwise → index+1, RD_ADDR.
- NEXT: if key==KEY_END → FAIL; else key←key+1, → LOAD.
- FOUND: found=1, key frozen. start=1 → restart from KEY_START via LOAD.
- FAIL: exhausted=1, key stays KEY_END. The key never wraps. start=1 → restart.
- busy=1 in LOAD, RUN, RD_ADDR, RD_WAIT, TEST, NEXT.
- core_reset = reset OR (state==LOAD). This is combinational, so the core is also reset whenever the controller is reset.
- core_start=1 only in RUN. msg_addr=0 outside RD_ADDR/RD_WAIT/TEST.
- start while busy is ignored. core_complete outside RUN is ignored.
- Key increment is a KEY_W-bit unsigned add. The index counter is ADDR_W bits; the TEST compare ends the scan before the counter wraps.

## Timing
- Reset values: state IDLE, key=KEY_START, index=0, core_start=0, core_reset=1 (while reset high, else 0), msg_addr=0, busy=0, found=0, exhausted=0.
- Reset mid-search returns to IDLE on the next edge. The core is held reset for as long as reset is high.
- Start to first core_start: start is sampled at edge E; LOAD runs in cycle E+1; core_start=1 from cycle E+2.
- A key stays constant from LOAD until NEXT. The core sees a stable key for its whole run.
- Per-byte check: 3 cycles. Full pass of MSG_LEN bytes: 3·MSG_LEN cycles after core_complete, then FOUND.
- An invalid byte at index i costs 3·(i+1) cycles. NEXT then LOAD follows, so each key adds 2 cycles of overhead plus the core runtime.
- found and exhausted are registered state decodes and are mutually exclusive. They stay asserted until start or reset.

## Test plan
- Core model returns all-'a' message for key 0 → found=1, key=0, exactly one core_reset pulse outside reset, 96 cycles from core_complete to found.
- Valid message only when key==3, otherwise byte 0 = 8'h00 → found with key=3, 4 LOAD pulses, core_start never high during core_reset.
- Key 0 message valid except byte 31 = 8'h7B, key 1 all spaces → key 0 rejected after 96 check cycles, found with key=1.
- Byte boundary sweep: 8'h60, 8'h7B, 8'h1F rejected; 8'h61, 8'h7A, 8'h20 accepted.
- KEY_START=0, KEY_END=5, no valid key → exhausted=1, key=5, no key 6 issued, busy=0; start then restarts at key 0.
- Reset asserted in RD_WAIT and in RUN → next cycle IDLE, all outputs at reset values, core_reset high throughout reset; start asserted while busy has no effect.

Source files
------------

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key-search scheduler.
// Steps through candidate keys. For each key it resets and starts the decrypt
// core, then scans the decrypted message for printable text. The search stops
// at the first key whose whole message is lowercase letters or spaces, or
// reports failure once KEY_END has been tried.
module rc4_key_search_ctrl #(
    parameter int              KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
    parameter int              MSG_LEN   = 32,
    parameter int              ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [KEY_W-1:0]  key,
    output logic              core_reset,
    output logic              core_start,
    input  logic              core_complete,
    output logic [ADDR_W-1:0] msg_addr,
    input  logic [7:0]        msg_q,
    output logic              busy,
    output logic              found,
    output logic              exhausted
);

    typedef enum logic [3:0] {
        IDLE, LOAD, RUN, RD_ADDR, RD_WAIT, TEST, NEXT, FOUND, FAIL
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            state, state_nxt;
    logic [KEY_W-1:0]  key_nxt;
    logic [ADDR_W-1:0] index, index_nxt;
    logic              byte_ok;

    // A byte passes if it is a lowercase letter or a space.
    assign byte_ok = ((msg_q >= 8'h61) && (msg_q <= 8'h7A)) || (msg_q == 8'h20);

    // State, current key and byte index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            key   <= KEY_START;
            index <= '0;
        end else begin
            state <= state_nxt;
            key   <= key_nxt;
            index <= index_nxt;
        end
    end

    // Next-state logic: key advances only in NEXT, so the core sees a stable key.
    always_comb begin
        state_nxt = state;
        key_nxt   = key;
        index_nxt = index;
        case (state)
            IDLE: begin
                if (start) begin
                    key_nxt   = KEY_START;
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = RUN;
            RUN: begin
                if (core_complete) begin
                    index_nxt = '0;
                    state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = TEST;
            TEST: begin
                if (!byte_ok) begin
                    state_nxt = NEXT;
                end else if (index == LAST_IDX) begin
                    state_nxt = FOUND;
                end else begin
                    index_nxt = index + ADDR_W'(1);
                    state_nxt = RD_ADDR;
                end
            end
            NEXT: begin
                // Stop at KEY_END rather than wrapping the key.
                if (key == KEY_END) begin
                    state_nxt = FAIL;
                end else begin
                    key_nxt   = key + KEY_W'(1);
                    state_nxt = LOAD;
                end
            end
            FOUND, FAIL: begin
                if (start) begin
                    key_nxt   = KEY_START;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Core controls: reset follows the controller reset combinationally, and
    // start is masked during reset so the two never overlap.
    assign core_reset = reset || (state == LOAD);
    assign core_start = (state == RUN) && !reset;

    // RAM address is only driven while a byte is being fetched or tested.
    assign msg_addr = ((state == RD_ADDR) || (state == RD_WAIT) || (state == TEST))
                      ? index : '0;

    // Status flags are plain decodes of the registered state.
    assign busy      = (state == LOAD) || (state == RUN) || (state == RD_ADDR) ||
                       (state == RD_WAIT) || (state == TEST) || (state == NEXT);
    assign found     = (state == FOUND);
    assign exhausted = (state == FAIL);

endmodule
